// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle multiply/divide unit for the execute stage.
//
// Handles MULT/MULTU (signed/unsigned 32x32->64) and DIV/DIVU (radix-2
// restoring divider, one quotient bit per cycle) and returns {HI,LO} for the
// execute-to-memory HILO write path.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE, and an offer is ignored while
// flush is high. out_valid stays high with stable out_hi/out_lo until
// out_ready is seen; it then drops the next cycle. The last result stays
// on out_hi/out_lo after the handshake.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   flush            kill any in-flight op, back to IDLE next cycle
//   in_valid/ready   operation offer / unit idle
//   in_op            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   in_a, in_b       rs (dividend/multiplicand), rt (divisor/multiplier)
//   out_valid/ready  result available / consumer takes it
//   out_hi, out_lo   product high/low word, or remainder/quotient
//   busy             state != IDLE (decode stalls MFHI/MFLO on it)
//   dbg_state        current FSM state
//
// Parameter MUL_LATENCY (1..4): cycles from accept to out_valid for multiplies.
// Optional macro MULDIV_EARLY_EXIT_EN: divides with |a| < |b| (b != 0) skip
// the iteration loop and finish in 3 cycles.
module execute_muldiv #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_DIV_ITER = 3'd2,
        S_DIV_FIX  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Last MUL-state count before DONE; unused when MUL_LATENCY == 1
    // because the accept goes straight to DONE.
    localparam logic [4:0] MUL_LAST = (MUL_LATENCY > 1) ? 5'(MUL_LATENCY - 2) : 5'd0;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [31:0] opa_q;        // multiplicand
    logic [31:0] opb_q;        // multiplier, or divisor magnitude
    logic [31:0] rem_q;        // partial remainder
    logic [31:0] quo_q;        // dividend magnitude shifting out, quotient shifting in
    logic        mul_signed_q;
    logic        sa_q, sb_q;

    logic        accept;
    logic        early_exit;
    logic [63:0] product;
    logic        div_sa, div_sb;
    logic [31:0] a_mag, b_mag;
    logic [32:0] div_shift, div_diff;

    function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] xe, ye;
        // Low 64 bits of the extended product are correct for both
        // signed and unsigned operands.
        xe = {{32{sgn & x[31]}}, x};
        ye = {{32{sgn & y[31]}}, y};
        return xe * ye;
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

    assign accept = in_valid && in_ready && !flush;

    // Signs only matter for signed DIV; DIVU forces them to zero.
    assign div_sa = ~in_op[0] & in_a[31];
    assign div_sb = ~in_op[0] & in_b[31];
    assign a_mag  = div_sa ? (32'd0 - in_a) : in_a;
    assign b_mag  = div_sb ? (32'd0 - in_b) : in_b;

    // With single-cycle latency the product is taken straight from the inputs.
    assign product = (MUL_LATENCY == 1) ? mul64(~in_op[0], in_a, in_b)
                                        : mul64(mul_signed_q, opa_q, opb_q);

    // One restoring step: bring down the next dividend bit and try to
    // subtract the divisor. Bit 32 of the difference is the borrow.
    assign div_shift = {rem_q, quo_q[31]};
    assign div_diff  = div_shift - {1'b0, opb_q};

`ifdef MULDIV_EARLY_EXIT_EN
    // On the first iteration quo_q still holds |a| untouched.
    assign early_exit = (state == S_DIV_ITER) && (cnt == 5'd0) &&
                        (opb_q != 32'd0) && (quo_q < opb_q);
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_op[1])              state_next = S_DIV_ITER;
                    else if (MUL_LATENCY == 1) state_next = S_DONE;
                    else                       state_next = S_MUL;
                end
            end
            S_MUL:      if (cnt == MUL_LAST) state_next = S_DONE;
            S_DIV_ITER: if (early_exit || cnt == 5'd31) state_next = S_DIV_FIX;
            S_DIV_FIX:  state_next = S_DONE;
            S_DONE:     if (out_ready) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt          <= 5'd0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            mul_signed_q <= 1'b0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            out_hi       <= 32'd0;
            out_lo       <= 32'd0;
        end else if (flush) begin
            cnt <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt          <= 5'd0;
                        mul_signed_q <= ~in_op[0];
                        opa_q        <= in_a;
                        opb_q        <= in_op[1] ? b_mag : in_b;
                        rem_q        <= 32'd0;
                        quo_q        <= a_mag;
                        sa_q         <= div_sa;
                        sb_q         <= div_sb;
                        if (!in_op[1] && MUL_LATENCY == 1) {out_hi, out_lo} <= product;
                    end
                end
                S_MUL: begin
                    if (cnt == MUL_LAST) begin
                        {out_hi, out_lo} <= product;
                        cnt              <= 5'd0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_DIV_ITER: begin
                    if (early_exit) begin
                        rem_q <= quo_q;
                        quo_q <= 32'd0;
                        cnt   <= 5'd0;
                    end else begin
                        if (!div_diff[32]) begin
                            rem_q <= div_diff[31:0];
                            quo_q <= {quo_q[30:0], 1'b1};
                        end else begin
                            rem_q <= div_shift[31:0];
                            quo_q <= {quo_q[30:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;  // wraps to 0 after the 32nd step
                    end
                end
                S_DIV_FIX: begin
                    out_lo <= (sa_q ^ sb_q) ? (32'd0 - quo_q) : quo_q;
                    out_hi <= sa_q ? (32'd0 - rem_q) : rem_q;
                end
                default: ;
            endcase
        end
    end

endmodule
